gpu_irq_ctrl: RTL and testbench
===============================

// Module: gpu_irq_ctrl
// PURPOSE
//  Multi-source GPU interrupt controller; parametrised successor of the single-flag sticky IRQ latch.
//  Collects NUM_SRC event lines (GP0 IRQ cmd, VBlank, DMA done, ...), latches each into a sticky pending bit.
//  Applies a per-source enable mask and drives one registered o_irq plus a priority-encoded source index.
//  Sits between GPU event producers and the CPU-side register interface (mask write, W1C ack).
// PARAMETERS
//  NUM_SRC    4        number of interrupt sources (1..16)
//  IDX_W      $clog2(NUM_SRC) (min 1)   width of o_irqIdx
//  EDGE_MASK  '1       per source: 1 = rising-edge triggered, 0 = level triggered
//  MASK_RST   '0       reset value of the enable mask
//  HOLDOFF    8        coalescing holdoff in cycles (used only with GPU_IRQ_COALESCE_EN; 1..255)
// PORTS
//  i_clk       in   1        clock
//  i_rst       in   1        synchronous reset, active-high
//  i_src       in   NUM_SRC  raw event lines, synchronous to i_clk
//  i_swSet     in   NUM_SRC  software force-set pulses
//  i_ack       in   NUM_SRC  write-1-to-clear pulses for pending bits
//  i_maskWr    in   1        mask write strobe
//  i_maskData  in   NUM_SRC  new mask value
//  o_pending   out  NUM_SRC  sticky pending flags (unmasked)
//  o_mask      out  NUM_SRC  current enable mask
//  o_irq       out  1        aggregated interrupt, registered
//  o_irqIdx    out  IDX_W    lowest-numbered pending&enabled source, registered
// BEHAVIOUR
//  - One clock i_clk; reset synchronous, active-high (i_rst). All state updates on posedge i_clk.
//  - Reset: pending=0, src_prev=0, mask=MASK_RST, o_irq=0, o_irqIdx=0, holdoff counter=0. Reset mid-operation drops
//    all pending events; i_src held high through reset counts as a new edge on the first cycle after reset.
//  - Trigger per source k: edge mode trig = i_src[k] & ~src_prev[k]; level mode trig = i_src[k]. src_prev <= i_src.
//  - Pending update: pend_n = (pend & ~i_ack) | trig | i_swSet. Set beats ack in the same cycle (no lost events).
//  - Level source still high after ack re-sets pending next cycle (ack without source removal is ineffective).
//  - Mask: i_maskWr loads i_maskData; mask does not gate pending latching, only o_irq/o_irqIdx.
//  - Latency: trig at cycle t -> o_pending at t+1 -> o_irq/o_irqIdx at t+2. Ack at t -> o_irq drops at t+2.
//  - o_irq <= |(pend_n_reg & mask) evaluated from registered pending/mask (one reg stage after pending).
//  - o_irqIdx <= lowest k with pending[k]&mask[k]; holds 0 when none. Valid only when o_irq=1.
//  - Mask write enabling an already pending source raises o_irq 1 cycle after the write is registered.
// CONFIGURATION
//  GPU_IRQ_COALESCE_EN defined: on every o_irq 1->0 transition an 8-bit counter loads HOLDOFF; while counter != 0
//    it decrements and o_irq is forced 0 (pending still latches). Counter reaching 0 re-enables o_irq next cycle.
//    Reset clears counter. o_irqIdx unaffected.
//  GPU_IRQ_COALESCE_EN undefined: no counter; o_irq reasserts as soon as any pending&mask bit is set.
// STRUCTURE
//  Package gpu_irq_pkg: GPU_IRQ_MAX_SRC=16, source index constants (IRQ_SRC_GP0, IRQ_SRC_VBLANK, IRQ_SRC_DMA,
//    IRQ_SRC_FIFO), typedef irq_vec_t = logic [GPU_IRQ_MAX_SRC-1:0], function lowest_set(vec) -> index.
//  Sub-module gpu_irq_src_cell: per-source edge/level detect + sticky pending bit, generated NUM_SRC times.
//  Top holds mask reg, priority encoder, output regs and optional holdoff counter.
// TESTING
//  1 Edge src0: i_src[0] 0->1 held 5 cycles, mask=4'b0001 -> o_pending[0]=1 at t+1, o_irq=1 at t+2, o_irqIdx=0,
//    single latch; i_ack[0] pulse -> o_irq=0 two cycles later, stays 0 while i_src[0] remains high.
//  2 Simultaneous: i_ack[1] and rising i_src[1] same cycle, mask=4'b0010 -> o_pending[1] stays 1, o_irq stays 1.
//  3 Masking/priority: pend sources 1 and 3, mask=4'b1000 -> o_irqIdx=3; write mask=4'b1010 -> o_irqIdx=1 next
//    cycle after registration; mask=0 -> o_irq=0 while o_pending=4'b1010.
//  4 Level src (EDGE_MASK=4'b1110, src0 level): i_src[0]=1, ack every cycle -> o_pending[0] re-sets each cycle,
//    o_irq stays 1; drop i_src[0] then ack -> o_irq=0.
//  5 Reset mid-op: pending=4'b1111, o_irq=1, i_rst pulse 1 cycle -> all outputs 0, o_mask=MASK_RST next cycle.
//  6 GPU_IRQ_COALESCE_EN, HOLDOFF=8: ack then new edge 2 cycles later -> o_irq low for exactly 8 cycles after drop,
//    o_pending set meanwhile, o_irq high on cycle 9; without macro o_irq high 2 cycles after the edge.

Source files
------------

// File: rtl/gpu_irq_pkg.sv
// Shared constants, vector type and priority helper for the GPU interrupt controller.
package gpu_irq_pkg;

   localparam int unsigned GPU_IRQ_MAX_SRC = 16;
   localparam int unsigned GPU_IRQ_IDX_W   = 4;

   // Conventional source assignment on the GPU event bus.
   localparam int unsigned IRQ_SRC_GP0    = 0;
   localparam int unsigned IRQ_SRC_VBLANK = 1;
   localparam int unsigned IRQ_SRC_DMA    = 2;
   localparam int unsigned IRQ_SRC_FIFO   = 3;

   typedef logic [GPU_IRQ_MAX_SRC-1:0] irq_vec_t;

   // Index of the lowest set bit; 0 when the vector is empty.
   function automatic logic [GPU_IRQ_IDX_W-1:0] lowest_set(input irq_vec_t vec);
      logic [GPU_IRQ_IDX_W-1:0] idx;
      idx = '0;
      for (int i = GPU_IRQ_MAX_SRC - 1; i >= 0; i--) begin
         if (vec[i]) idx = GPU_IRQ_IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/gpu_irq_src_cell.sv
// One interrupt source: edge/level trigger detect feeding a sticky pending bit.
module gpu_irq_src_cell #(
   parameter logic EDGE = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic src_i,
   input  logic sw_set_i,
   input  logic ack_i,
   output logic pending_o
);

   logic src_prev_q, src_prev_d;
   logic pend_q, pend_d;
   logic trig;

   // Trigger detect and pending next-state; a set in the same cycle as an ack wins.
   always_comb begin
      trig       = EDGE ? (src_i & ~src_prev_q) : src_i;
      src_prev_d = src_i;
      pend_d     = (pend_q & ~ack_i) | trig | sw_set_i;
   end

   // State registers; reset clears history so a source held high re-triggers afterwards.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         src_prev_q <= 1'b0;
         pend_q     <= 1'b0;
      end else begin
         src_prev_q <= src_prev_d;
         pend_q     <= pend_d;
      end
   end

   assign pending_o = pend_q;

endmodule

// File: rtl/gpu_irq_ctrl.sv
// Multi-source GPU interrupt controller: sticky pending bits, enable mask, registered
// aggregated IRQ and lowest-index source. Define GPU_IRQ_COALESCE_EN to add a holdoff
// counter that keeps o_irq low for HOLDOFF cycles after each deassertion.
module gpu_irq_ctrl
   import gpu_irq_pkg::*;
#(
   parameter int unsigned        NUM_SRC   = 4,
   parameter int unsigned        IDX_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
   parameter logic [NUM_SRC-1:0] EDGE_MASK = '1,
   parameter logic [NUM_SRC-1:0] MASK_RST  = '0,
   parameter int unsigned        HOLDOFF   = 8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [NUM_SRC-1:0] i_src,
   input  logic [NUM_SRC-1:0] i_swSet,
   input  logic [NUM_SRC-1:0] i_ack,
   input  logic               i_maskWr,
   input  logic [NUM_SRC-1:0] i_maskData,
   output logic [NUM_SRC-1:0] o_pending,
   output logic [NUM_SRC-1:0] o_mask,
   output logic               o_irq,
   output logic [IDX_W-1:0]   o_irqIdx
);

   if (NUM_SRC < 1 || NUM_SRC > GPU_IRQ_MAX_SRC || HOLDOFF < 1 || HOLDOFF > 255) begin : g_bad_cfg
      $error("gpu_irq_ctrl: NUM_SRC or HOLDOFF out of range");
   end

   logic [NUM_SRC-1:0] pend;
   logic [NUM_SRC-1:0] mask_q, mask_d;
   logic               irq_q, irq_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [NUM_SRC-1:0] act;
   irq_vec_t           act_ext;
   logic               raw_irq;

   for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
      gpu_irq_src_cell #(
         .EDGE (EDGE_MASK[k])
      ) u_cell (
         .clk_i     (i_clk),
         .rst_i     (i_rst),
         .src_i     (i_src[k]),
         .sw_set_i  (i_swSet[k]),
         .ack_i     (i_ack[k]),
         .pending_o (pend[k])
      );
   end

`ifdef GPU_IRQ_COALESCE_EN
   logic [7:0] hold_q, hold_d;
   logic       hold_load;

   // Holdoff: reload on every o_irq fall, count down, release o_irq once the next count is 0.
   // While o_irq is high the counter is already 0, so the load depends only on raw_irq.
   always_comb begin
      hold_load = irq_q & ~raw_irq;
      if (hold_load) begin
         hold_d = 8'(HOLDOFF);
      end else if (hold_q != 8'd0) begin
         hold_d = hold_q - 8'd1;
      end else begin
         hold_d = 8'd0;
      end
   end

   // Holdoff counter register.
   always_ff @(posedge i_clk) begin
      if (i_rst) hold_q <= 8'd0;
      else       hold_q <= hold_d;
   end
`endif

   // Mask update and output next-state from registered pending/mask.
   always_comb begin
      mask_d = i_maskWr ? i_maskData : mask_q;
      act    = pend & mask_q;
      raw_irq = |act;
      act_ext = '0;
      act_ext[NUM_SRC-1:0] = act;
      idx_d  = IDX_W'(lowest_set(act_ext));
`ifdef GPU_IRQ_COALESCE_EN
      irq_d  = raw_irq & (hold_d == 8'd0);
`else
      irq_d  = raw_irq;
`endif
   end

   // Mask and output registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         mask_q <= MASK_RST;
         irq_q  <= 1'b0;
         idx_q  <= '0;
      end else begin
         mask_q <= mask_d;
         irq_q  <= irq_d;
         idx_q  <= idx_d;
      end
   end

   assign o_pending = pend;
   assign o_mask    = mask_q;
   assign o_irq     = irq_q;
   assign o_irqIdx  = idx_q;

endmodule

// File: tb/tb_gpu_irq_ctrl.sv
// Directed bench for gpu_irq_ctrl: an all-edge instance and one with source 0 level-triggered.
module tb_gpu_irq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] src, sw, ack, mdata;
   logic       mwr;

   logic [3:0] pend_e, mask_e, pend_l, mask_l;
   logic       irq_e, irq_l;
   logic [1:0] idx_e, idx_l;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   gpu_irq_ctrl dut_e (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_src      (src),
      .i_swSet    (sw),
      .i_ack      (ack),
      .i_maskWr   (mwr),
      .i_maskData (mdata),
      .o_pending  (pend_e),
      .o_mask     (mask_e),
      .o_irq      (irq_e),
      .o_irqIdx   (idx_e)
   );

   gpu_irq_ctrl #(
      .EDGE_MASK (4'b1110)
   ) dut_l (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_src      (src),
      .i_swSet    (sw),
      .i_ack      (ack),
      .i_maskWr   (mwr),
      .i_maskData (mdata),
      .o_pending  (pend_l),
      .o_mask     (mask_l),
      .o_irq      (irq_l),
      .o_irqIdx   (idx_l)
   );

   // Advance one clock; outputs are sampled and inputs changed 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic write_mask(input logic [3:0] m);
      mwr   = 1'b1;
      mdata = m;
      tick();
      mwr   = 1'b0;
   endtask

   initial begin
      src = '0; sw = '0; ack = '0; mwr = 1'b0; mdata = '0;
      do_reset();
      chk("rst_pend", 32'(pend_e), 0);
      chk("rst_mask", 32'(mask_e), 0);
      chk("rst_irq", 32'(irq_e), 0);
      chk("rst_idx", 32'(idx_e), 0);
      chk("rst_pend_l", 32'(pend_l), 0);

      // 1: edge source 0, single latch, ack while source stays high.
      write_mask(4'b0001);
      chk("t1_mask", 32'(mask_e), 32'h1);
      src = 4'b0001;
      tick();
      chk("t1_pend_t1", 32'(pend_e), 32'h1);
      chk("t1_irq_t1", 32'(irq_e), 0);
      tick();
      chk("t1_irq_t2", 32'(irq_e), 1);
      chk("t1_idx", 32'(idx_e), 0);
      tick();
      chk("t1_single", 32'(pend_e), 32'h1);
      ack = 4'b0001;
      tick();
      ack = 4'b0000;
      chk("t1_ack_pend", 32'(pend_e), 0);
      chk("t1_ack_irq1", 32'(irq_e), 1);
      tick();
      chk("t1_ack_irq2", 32'(irq_e), 0);
      tick();
      chk("t1_hold_irq", 32'(irq_e), 0);
      chk("t1_hold_pend", 32'(pend_e), 0);
      src = 4'b0000;
      tick();

      // 2: ack and a fresh rising edge in the same cycle; the set must win.
      do_reset();
      write_mask(4'b0010);
      src = 4'b0010;
      tick();
      src = 4'b0000;
      tick();
      chk("t2_irq_pre", 32'(irq_e), 1);
      src = 4'b0010;
      ack = 4'b0010;
      tick();
      ack = 4'b0000;
      chk("t2_pend", 32'(pend_e), 32'h2);
      tick();
      chk("t2_irq_a", 32'(irq_e), 1);
      tick();
      chk("t2_irq_b", 32'(irq_e), 1);
      src = 4'b0000;

      // 3: masking and priority between sources 1 and 3.
      do_reset();
      sw    = 4'b1010;
      mwr   = 1'b1;
      mdata = 4'b1000;
      tick();
      sw  = 4'b0000;
      mwr = 1'b0;
      chk("t3_pend", 32'(pend_e), 32'ha);
      tick();
      chk("t3_irq", 32'(irq_e), 1);
      chk("t3_idx3", 32'(idx_e), 3);
      write_mask(4'b1010);
      chk("t3_idx_hold", 32'(idx_e), 3);
      tick();
      chk("t3_idx1", 32'(idx_e), 1);
      write_mask(4'b0000);
      tick();
      chk("t3_irq_masked", 32'(irq_e), 0);
      chk("t3_pend_kept", 32'(pend_l), 32'ha);
      chk("t3_pend_kept_e", 32'(pend_e), 32'ha);
      write_mask(4'b0010);
      tick();
      chk("t3_unmask_irq", 32'(irq_e), 1);
      chk("t3_unmask_idx", 32'(idx_e), 1);

      // 4: level source 0 on dut_l; ack cannot clear while the level is held.
      do_reset();
      write_mask(4'b0001);
      src = 4'b0001;
      ack = 4'b0001;
      tick();
      chk("t4_pend_set", 32'(pend_l), 32'h1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t4_pend_re", 32'(pend_l), 32'h1);
         chk("t4_irq_on", 32'(irq_l), 1);
      end
      src = 4'b0000;
      tick();
      chk("t4_pend_clr", 32'(pend_l), 0);
      tick();
      ack = 4'b0000;
      chk("t4_irq_off", 32'(irq_l), 0);

      // 5: reset mid-operation; a source held through reset re-triggers afterwards.
      do_reset();
      sw    = 4'b1111;
      mwr   = 1'b1;
      mdata = 4'b1111;
      tick();
      sw  = 4'b0000;
      mwr = 1'b0;
      tick();
      chk("t5_pre_irq", 32'(irq_e), 1);
      chk("t5_pre_pend", 32'(pend_e), 32'hf);
      rst = 1'b1;
      src = 4'b0100;
      tick();
      rst = 1'b0;
      chk("t5_pend", 32'(pend_e), 0);
      chk("t5_mask", 32'(mask_e), 0);
      chk("t5_irq", 32'(irq_e), 0);
      chk("t5_idx", 32'(idx_e), 0);
      tick();
      chk("t5_reedge", 32'(pend_e), 32'h4);
      src = 4'b0000;

      // 6: ack then a new edge two cycles later.
      do_reset();
      write_mask(4'b0001);
      src = 4'b0001;
      tick();
      src = 4'b0000;
      tick();
      chk("t6_irq_pre", 32'(irq_e), 1);
      ack = 4'b0001;
      tick();
      ack = 4'b0000;
      tick();
      chk("t6_drop", 32'(irq_e), 0);
      src = 4'b0001;
      tick();
      chk("t6_pend", 32'(pend_e), 32'h1);
`ifdef GPU_IRQ_COALESCE_EN
      chk("t6_hold_c2", 32'(irq_e), 0);
      for (int i = 3; i <= 8; i++) begin
         tick();
         chk("t6_hold", 32'(irq_e), 0);
      end
      tick();
      chk("t6_release", 32'(irq_e), 1);
`else
      tick();
      chk("t6_reassert", 32'(irq_e), 1);
`endif
      src = 4'b0000;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
